// File: rtl/fft_sdf_sequencer.sv
// Control sequencer for a pipelined radix-2 DIF single-delay-feedback FFT.
// A single timeline counter t starts on the first accepted sample. Every stage
// strobe is a fixed function of t, and no sample data passes through this block.
module fft_sdf_sequencer #(
  parameter int N     = 32,
  parameter int LOG2N = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           zero_fill,
  output logic [LOG2N-1:0]               bf_mode,
  output logic [LOG2N-2:0]               mult_cnt_en,
  output logic [(LOG2N-1)*(LOG2N-1)-1:0] tw_idx,
  output logic                           out_valid,
  output logic [LOG2N-1:0]               out_idx,
  output logic                           busy,
  output logic                           done,
  output logic                           frame_err
);

  localparam int TW  = LOG2N - 1;       // twiddle index field width
  localparam int TB  = LOG2N + 2;       // timeline width; LAT+N-1 < 4N, so t never wraps
  localparam int LAT = N + 2*LOG2N - 2; // t of the first FFT output
  localparam logic [TB-1:0] T_LOAD_END = TB'(N - 1);
  localparam logic [TB-1:0] T_LAST     = TB'(LAT + N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  // Pipeline offset L_s of stage s. Each earlier stage adds its delay line,
  // one butterfly register and one multiplier register.
  function automatic int stage_offset(input int s);
    int l;
    l = 0;
    for (int i = 0; i < s; i++) l = l + (N >> (i + 1)) + 2;
    return l;
  endfunction

  state_t         state_q, state_d;
  logic [TB-1:0]  t_q, t_d;
  logic           done_d, err_d;

  // Status outputs are decoded straight from the state register.
  assign in_ready  = (state_q != DRAIN);
  assign busy      = (state_q != IDLE);
  assign zero_fill = (state_q == DRAIN);

  // Next state and timeline. An accept in IDLE is sample 0 at t=0, so the
  // first LOAD cycle already carries t=1.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d = state_q;
    t_d     = t_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = LOAD;
          t_d     = t_q + 1'b1;
        end
      end
      LOAD: begin
        if (!in_valid) begin
          state_d = IDLE;
          t_d     = '0;
          err_d   = 1'b1;
        end else begin
          t_d = t_q + 1'b1;
          if (t_q == T_LOAD_END) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (t_q == T_LAST) begin
          state_d = IDLE;
          t_d     = '0;
          done_d  = 1'b1;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  // Strobes are evaluated for the next timeline value and then registered,
  // so each one lines up with the cycle its sample reaches the block it controls.
  logic             busy_d;
  int               t_d_int;
  logic [LOG2N-1:0] bf_d;
  logic [LOG2N-2:0] mult_d;
  logic [TW*TW-1:0] tw_d;

  assign busy_d  = (state_d != IDLE);
  assign t_d_int = int'(t_d);

  for (genvar s = 0; s < LOG2N; s++) begin : g_stage
    localparam int D = N >> (s + 1);
    localparam int L = stage_offset(s);
    int c;
    assign c = t_d_int - L;
    // The butterfly is active in the second half of every 2*D_s period of the input window.
    assign bf_d[s] = busy_d && (c >= 0) && (c < N) && ((c & D) != 0);
    if (s < LOG2N - 1) begin : g_mult
      int   m;
      logic hit;
      assign m   = c - 1;
      // The multiplier sits one register behind the butterfly that feeds it.
      assign hit = busy_d && (m >= D) && (m < N + D) && ((m & D) != 0);
      assign mult_d[s]        = hit;
      assign tw_d[s*TW +: TW] = hit ? TW'((m & (D - 1)) << s) : '0;
    end
  end

  // Output bins leave the pipeline in bit-reversed order. Mirroring the
  // output count gives the natural-order bin index.
  int               o;
  logic [LOG2N-1:0] o_bits, o_rev;
  logic             ov_d;

  assign o      = t_d_int - LAT;
  assign o_bits = o[LOG2N-1:0];
  assign ov_d   = busy_d && (o >= 0) && (o < N);

  for (genvar b = 0; b < LOG2N; b++) begin : g_rev
    assign o_rev[b] = o_bits[LOG2N-1-b];
  end

  // State, timeline and registered strobes. An asynchronous reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      t_q         <= '0;
      bf_mode     <= '0;
      mult_cnt_en <= '0;
      tw_idx      <= '0;
      out_valid   <= 1'b0;
      out_idx     <= '0;
      done        <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      state_q     <= state_d;
      t_q         <= t_d;
      bf_mode     <= bf_d;
      mult_cnt_en <= mult_d;
      tw_idx      <= tw_d;
      out_valid   <= ov_d;
      out_idx     <= ov_d ? o_rev : '0;
      done        <= done_d;
      frame_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_fft_sdf_sequencer.sv
// Testbench for fft_sdf_sequencer. A cycle-level reference model derives
// every strobe from the frame timeline, and literal pins anchor that model.
module tb_fft_sdf_sequencer;

  localparam int N    = 32;
  localparam int S    = 5;
  localparam int TW   = S - 1;
  localparam int TWW  = TW * TW;
  localparam int LAT  = N - 1 + 2*S - 1;
  localparam int LAST = LAT + N - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready, zero_fill, out_valid, busy, done, frame_err;
  logic [S-1:0]   bf_mode, out_idx;
  logic [S-2:0]   mult_cnt_en;
  logic [TWW-1:0] tw_idx;

  always #5 clk = ~clk;

  fft_sdf_sequencer #(.N(N), .LOG2N(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .zero_fill(zero_fill), .bf_mode(bf_mode), .mult_cnt_en(mult_cnt_en),
    .tw_idx(tw_idx), .out_valid(out_valid), .out_idx(out_idx), .busy(busy),
    .done(done), .frame_err(frame_err)
  );

  int tests = 0;
  int fails = 0;
  int pin_mode = 0;

  // Reference model state for the cycle about to be sampled.
  bit m_busy, m_done, m_err;
  int m_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (model t=%0d busy=%0d)", name, act, exp, m_t, m_busy);
    end
  endtask

  function automatic int stage_d(input int s);
    return N / (2 ** (s + 1));
  endfunction

  function automatic int stage_l(input int s);
    int l;
    l = 0;
    for (int i = 0; i < s; i++) l = l + stage_d(i) + 2;
    return l;
  endfunction

  function automatic int bitrev(input int v);
    int r;
    r = 0;
    for (int b = 0; b < S; b++)
      if (((v / (2 ** b)) % 2) == 1) r = r + 2 ** (S - 1 - b);
    return r;
  endfunction

  // Compare every output with the model. In the directed phases, also check literal pins.
  task automatic check_cycle();
    logic [S-1:0]   e_bf, e_oi;
    logic [S-2:0]   e_me;
    logic [TWW-1:0] e_tw;
    logic           e_ov;
    int c, m, d;
    e_bf = '0; e_oi = '0; e_me = '0; e_tw = '0; e_ov = 1'b0;
    if (m_busy) begin
      for (int s = 0; s < S; s++) begin
        d = stage_d(s);
        c = m_t - stage_l(s);
        if (c >= 0 && c < N && (c % (2 * d)) >= d) e_bf = e_bf | (S'(1) << s);
        if (s < S - 1) begin
          m = c - 1;
          if (m >= d && m < N + d && (m % (2 * d)) >= d) begin
            e_me = e_me | ((S-1)'(1) << s);
            e_tw = e_tw | (TWW'((m % d) * (2 ** s)) << (s * TW));
          end
        end
      end
      if (m_t >= LAT && m_t <= LAST) begin
        e_ov = 1'b1;
        e_oi = S'(bitrev(m_t - LAT));
      end
    end
    check("in_ready",    64'(in_ready),    64'(!m_busy || m_t < N));
    check("busy",        64'(busy),        64'(m_busy));
    check("zero_fill",   64'(zero_fill),   64'(m_busy && m_t >= N));
    check("bf_mode",     64'(bf_mode),     64'(e_bf));
    check("mult_cnt_en", 64'(mult_cnt_en), 64'(e_me));
    check("tw_idx",      64'(tw_idx),      64'(e_tw));
    check("out_valid",   64'(out_valid),   64'(e_ov));
    check("out_idx",     64'(out_idx),     64'(e_oi));
    check("done",        64'(done),        64'(m_done));
    check("frame_err",   64'(frame_err),   64'(m_err));

    if (pin_mode == 1 && m_busy) begin
      if (m_t == 15) check("pin_bf0_t15", 64'(bf_mode[0]), 64'd0);
      if (m_t == 16) check("pin_bf0_t16", 64'(bf_mode[0]), 64'd1);
      if (m_t == 17) begin
        check("pin_me0_t17", 64'(mult_cnt_en[0]), 64'd1);
        check("pin_tw0_t17", 64'(tw_idx[3:0]), 64'd0);
      end
      if (m_t == 26) check("pin_bf1_t26", 64'(bf_mode[1]), 64'd1);
      if (m_t == 27) check("pin_tw1_t27", 64'(tw_idx[7:4]), 64'd0);
      if (m_t == 28) check("pin_tw1_t28", 64'(tw_idx[7:4]), 64'd2);
      if (m_t == 32) begin
        check("pin_bf0_t32", 64'(bf_mode[0]), 64'd0);
        check("pin_tw0_t32", 64'(tw_idx[3:0]), 64'd15);
        check("pin_rdy_t32", 64'(in_ready), 64'd0);
      end
      if (m_t == 34) check("pin_tw1_t34", 64'(tw_idx[7:4]), 64'd14);
      if (m_t == 41) check("pin_bf1_t41", 64'(bf_mode[1]), 64'd0);
      if (m_t == 42) check("pin_bf1_t42", 64'(bf_mode[1]), 64'd1);
      if (m_t == 39) check("pin_ov_t39", 64'(out_valid), 64'd0);
      if (m_t == 40) check("pin_oi_t40", 64'({out_valid, out_idx}), 64'({1'b1, 5'd0}));
      if (m_t == 41) check("pin_oi_t41", 64'(out_idx), 64'd16);
      if (m_t == 42) check("pin_oi_t42", 64'(out_idx), 64'd8);
      if (m_t == 43) check("pin_oi_t43", 64'(out_idx), 64'd24);
      if (m_t == 71) check("pin_oi_t71", 64'(out_idx), 64'd31);
    end
    if (pin_mode == 1 && m_done) check("pin_done", 64'({done, busy}), 64'({1'b1, 1'b0}));
    if (pin_mode == 2 && m_err)  check("pin_err",  64'({frame_err, busy, out_valid}), 64'({1'b1, 1'b0, 1'b0}));
    if (pin_mode == 3 && m_done) check("pin_b2b_rdy", 64'({done, in_ready}), 64'({1'b1, 1'b1}));
  endtask

  // Advance the model by one clock, given the in_valid of the current cycle.
  task automatic model_step(input logic iv);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (!m_busy) begin
      if (iv) begin
        m_busy = 1'b1;   // the sample accepted now was t=0
        m_t    = 1;
      end
    end else if (m_t < N) begin
      if (!iv) begin
        m_busy = 1'b0;
        m_t    = 0;
        m_err  = 1'b1;
      end else begin
        m_t++;
      end
    end else if (m_t == LAST) begin
      m_busy = 1'b0;
      m_t    = 0;
      m_done = 1'b1;
    end else begin
      m_t++;
    end
  endtask

  task automatic run_cycle(input logic iv);
    @(negedge clk);
    check_cycle();
    in_valid = iv;
    model_step(iv);
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_t = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_others"},
          64'({zero_fill, bf_mode, mult_cnt_en, out_valid, out_idx, busy, done, frame_err}), 64'd0);
    check({tag, "_tw_idx"}, 64'(tw_idx), 64'd0);
  endtask

  logic iv_r;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Directed full frame: stage 0 and stage 1 strobes, the output order and done.
    pin_mode = 1;
    for (int i = 0; i < N; i++) run_cycle(1'b1);
    while (m_busy) run_cycle(1'b0);
    run_cycle(1'b0);

    // Drop in_valid during LOAD at t=10.
    pin_mode = 2;
    for (int i = 0; i < 10; i++) run_cycle(1'b1);
    run_cycle(1'b0);
    repeat (4) run_cycle(1'b0);

    // Back-to-back frames with in_valid held high.
    pin_mode = 3;
    repeat (2 * (LAST + 2) + 4) run_cycle(1'b1);
    while (m_busy) run_cycle(1'b0);
    run_cycle(1'b0);

    // Random traffic, including occasional aborted frames.
    pin_mode = 0;
    repeat (3000) begin
      if (!m_busy)      iv_r = ($urandom_range(0, 3) == 0);
      else if (m_t < N) iv_r = ($urandom_range(0, 49) != 0);
      else              iv_r = 1'($urandom_range(0, 1));
      run_cycle(iv_r);
    end
    while (m_busy) run_cycle(1'b0);
    run_cycle(1'b0);

    // Assert reset in DRAIN at t=50. Outputs must clear within the same cycle.
    for (int i = 0; i < N; i++) run_cycle(1'b1);
    while (m_t != 50) run_cycle(1'b0);
    @(posedge clk);
    #2;
    check("pre_rst_busy", 64'({busy, zero_fill}), 64'({1'b1, 1'b1}));
    rst = 1'b1;
    #1;
    check_reset_values("rst_drain");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(in_ready), 64'd1);
    repeat (4) run_cycle(1'b0);
    for (int i = 0; i < N; i++) run_cycle(1'b1);
    while (m_busy) run_cycle(1'b0);
    run_cycle(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
